data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Responder end of the CPU data-memory bus: address/write-data/write-valid in, read-data out.
//  Holds a DEPTH-word data RAM mapped at BASE_ADDR.
//  Read path is combinational with a lane shift. Writes are posted through a one-entry write buffer.
//  Faulting writes are flagged with a sticky error and address capture.
// PARAMETERS
//  XLEN       32            data/address width
//  DEPTH      1024          RAM size in XLEN-bit words (power of 2)
//  BASE_ADDR  32'h0000_2000 byte address of word 0 (DEPTH*4-aligned)
// PORTS
//  i_clk         in   1     clock
//  i_rst         in   1     reset, asynchronous, active-high
//  i_addr        in   XLEN  byte address (valid every cycle)
//  i_wvalid      in   1     write request this cycle
//  i_wdata       in   XLEN  write data, full word
//  o_rdata       out  XLEN  read data for i_addr, same cycle
//  o_err         out  1     sticky write-fault flag
//  o_err_addr    out  XLEN  address of first faulting write
//  o_wr_count    out  32    committed-write counter
// BEHAVIOUR
//  Decode
//   - in_range = BASE_ADDR <= i_addr < BASE_ADDR + 4*DEPTH.
//   - idx = i_addr[$clog2(DEPTH)+1:2]; lane = i_addr[1:0].
//  Read (combinational, 0 latency)
//   - word = (wb_valid && wb_idx==idx) ? wb_data : ram[idx]  (forwarding from the write buffer).
//   - o_rdata = word >> (8*lane), zero-filled; o_rdata = 0 when !in_range.
//   - Reads never fault.
//  Write buffer (wb_valid, wb_idx, wb_data)
//   - Accept: i_wvalid && in_range && lane==0.
//   - Every posedge: if wb_valid, write ram[wb_idx] <= wb_data and o_wr_count++.
//   - The buffer then reloads with the accepted write, or clears (wb_valid <= 0).
//   - Back-to-back writes: drain and refill on the same edge; there is no stall.
//   - Write then read of the same word next cycle returns the new data via forwarding.
//   - Two writes to the same idx in consecutive cycles: the later data wins.
//  Fault (i_wvalid && (!in_range || lane!=0))
//   - The write is dropped; o_err <= 1.
//   - o_err_addr <= i_addr only if o_err was 0 (first fault held).
//   - o_err clears only on reset.
//  Counter
//   - o_wr_count saturates at 32'hFFFF_FFFF.
//  Reset
//   - wb_valid=0, o_err=0, o_err_addr=0, o_wr_count=0.
//   - RAM contents are not reset.
//   - A write accepted in the cycle reset asserts, or pending in the buffer, is lost.
//   - o_rdata during reset = ram word (forwarding inactive).
// CONFIGURATION
//  DMEM_STATS_EN
//   - Defined: o_wr_count is implemented as above.
//   - Undefined: no counter flops; o_wr_count tied to 0.
//   - All other behaviour is identical either way.
// STRUCTURE
//  Shared package rv32i_pkg
//   - localparam DMEM_BASE_ADDR, DMEM_DEPTH defaults.
//   - typedef dmem_wbuf_t {logic valid; logic [IDXW-1:0] idx; logic [XLEN-1:0] data}.
//  Sub-module dmem_write_buffer
//   - Holds dmem_wbuf_t and the drain/refill logic.
//   - Outputs the forward-hit and forward-data signals.
//  Top level: decode, RAM array, lane shift, fault/counter logic.
// TESTING
//  T1 reset
//   - Assert i_rst mid-cycle with a write pending -> o_err=0, o_wr_count=0.
//   - Read of that word returns the old value.
//  T2 write forwarding
//   - Write 0xDEADBEEF @0x2000, read 0x2000 next cycle -> 0xDEADBEEF.
//   - Read 0x2002 -> 0x0000DEAD; read 0x2003 -> 0x000000DE.
//  T3 back-to-back writes
//   - Writes to 0x2004 (0x11), then 0x2004 (0x22), then 0x2008 (0x33) on consecutive cycles.
//   - Reads -> 0x22 @0x2004, 0x33 @0x2008; o_wr_count=3.
//  T4 faults
//   - Write @0x1FFC -> o_err=1, o_err_addr=0x1FFC.
//   - Then write @0x2001 -> o_err_addr stays 0x1FFC; RAM unchanged.
//   - Read @0x1FFC -> 0.
//  T5 boundary
//   - Write/read last word 0x2FFC (DEPTH=1024) -> data returned, no error.
//   - Write @0x3000 -> o_err=1.
//  T6 DMEM_STATS_EN undefined
//   - Rerun T3 -> data identical, o_wr_count=0.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared RV32I data-memory definitions: default memory map, write-buffer entry
// type and the read-lane alignment helper.
package rv32i_pkg;

  localparam int unsigned DMEM_XLEN      = 32;
  localparam logic [31:0] DMEM_BASE_ADDR = 32'h0000_2000;
  localparam int unsigned DMEM_DEPTH     = 1024;
  localparam int unsigned DMEM_IDXW      = $clog2(DMEM_DEPTH);

  typedef struct packed {
    logic                 valid;
    logic [DMEM_IDXW-1:0] idx;
    logic [DMEM_XLEN-1:0] data;
  } dmem_wbuf_t;

  // Right-align the addressed byte lane, zero-filling the vacated upper bytes.
  function automatic logic [DMEM_XLEN-1:0] lane_shift(input logic [DMEM_XLEN-1:0] word,
                                                      input logic [1:0]           lane);
    return word >> {lane, 3'b000};
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// CPU data-memory bus: the load/store unit is the master, the data-memory
// responder is the slave.
interface data_mem_responder_if #(
  parameter int unsigned XLEN = 32
);

  logic [XLEN-1:0] i_addr;
  logic            i_wvalid;
  logic [XLEN-1:0] i_wdata;
  logic [XLEN-1:0] o_rdata;
  logic            o_err;
  logic [XLEN-1:0] o_err_addr;
  logic [31:0]     o_wr_count;

  modport master (
    output i_addr, i_wvalid, i_wdata,
    input  o_rdata, o_err, o_err_addr, o_wr_count
  );

  modport slave (
    input  i_addr, i_wvalid, i_wdata,
    output o_rdata, o_err, o_err_addr, o_wr_count
  );

endinterface

// File: rtl/data_mem_responder_write_buffer.sv
// One-entry posted write buffer: drains to the RAM on every edge it is valid
// and refills with the write accepted in the same cycle; supplies read forwarding.
module dmem_write_buffer
  import rv32i_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_accept,
  input  logic [DMEM_IDXW-1:0] i_idx,
  input  logic [DMEM_XLEN-1:0] i_data,
  input  logic [DMEM_IDXW-1:0] i_rd_idx,
  output logic                 o_drain,
  output logic [DMEM_IDXW-1:0] o_drain_idx,
  output logic [DMEM_XLEN-1:0] o_drain_data,
  output logic                 o_fwd_hit,
  output logic [DMEM_XLEN-1:0] o_fwd_data
);

  dmem_wbuf_t wbuf_q;
  dmem_wbuf_t wbuf_d;

  // Contents are drained unconditionally, so the next state only depends on the new accept.
  always_comb begin
    wbuf_d       = wbuf_q;
    wbuf_d.valid = i_accept;
    if (i_accept) begin
      wbuf_d.idx  = i_idx;
      wbuf_d.data = i_data;
    end else begin
      wbuf_d.idx  = wbuf_q.idx;
      wbuf_d.data = wbuf_q.data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wbuf_q <= '0;
    end else begin
      wbuf_q <= wbuf_d;
    end
  end

  assign o_drain      = wbuf_q.valid;
  assign o_drain_idx  = wbuf_q.idx;
  assign o_drain_data = wbuf_q.data;
  assign o_fwd_hit    = wbuf_q.valid && (wbuf_q.idx == i_rd_idx);
  assign o_fwd_data   = wbuf_q.data;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: address decode, word RAM, combinational lane-shifted reads,
// posted writes, sticky write-fault capture. Define DMEM_STATS_EN for the write counter.
module data_mem_responder
  import rv32i_pkg::*;
#(
  parameter int unsigned     XLEN      = DMEM_XLEN,
  parameter int unsigned     DEPTH     = DMEM_DEPTH,
  parameter logic [XLEN-1:0] BASE_ADDR = DMEM_BASE_ADDR
) (
  input logic                 i_clk,
  input logic                 i_rst,
  data_mem_responder_if.slave bus
);

  localparam int unsigned   IDXW     = $clog2(DEPTH);
  localparam logic [XLEN:0] END_ADDR = {1'b0, BASE_ADDR} + (XLEN+1)'(4 * DEPTH);

  logic            in_range;
  logic [IDXW-1:0] idx;
  logic [1:0]      lane;
  logic            accept;
  logic            fault;

  logic            wb_drain;
  logic [IDXW-1:0] wb_drain_idx;
  logic [XLEN-1:0] wb_drain_data;
  logic            fwd_hit;
  logic [XLEN-1:0] fwd_data;

  logic [XLEN-1:0] ram [DEPTH];
  logic [XLEN-1:0] word;
  logic [XLEN-1:0] rdata;

  logic            err_q, err_d;
  logic [XLEN-1:0] err_addr_q, err_addr_d;

  // The upper bound is compared one bit wider so a map ending at the top of the space cannot wrap.
  assign in_range = (bus.i_addr >= BASE_ADDR) && ({1'b0, bus.i_addr} < END_ADDR);
  assign idx      = bus.i_addr[IDXW+1:2];
  assign lane     = bus.i_addr[1:0];
  assign accept   = bus.i_wvalid && in_range && (lane == 2'd0);
  assign fault    = bus.i_wvalid && !accept;

  dmem_write_buffer u_wbuf (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_accept     (accept),
    .i_idx        (idx),
    .i_data       (bus.i_wdata),
    .i_rd_idx     (idx),
    .o_drain      (wb_drain),
    .o_drain_idx  (wb_drain_idx),
    .o_drain_data (wb_drain_data),
    .o_fwd_hit    (fwd_hit),
    .o_fwd_data   (fwd_data)
  );

  always_ff @(posedge i_clk) begin
    if (wb_drain) begin
      ram[wb_drain_idx] <= wb_drain_data;
    end
  end

  always_comb begin
    word = fwd_hit ? fwd_data : ram[idx];
    if (in_range) begin
      rdata = lane_shift(word, lane);
    end else begin
      rdata = '0;
    end
  end

  assign bus.o_rdata = rdata;

  // Only the first faulting address is kept until reset.
  always_comb begin
    err_d      = err_q;
    err_addr_d = err_addr_q;
    if (fault) begin
      err_d = 1'b1;
      if (!err_q) begin
        err_addr_d = bus.i_addr;
      end else begin
        err_addr_d = err_addr_q;
      end
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign bus.o_err      = err_q;
  assign bus.o_err_addr = err_addr_q;

`ifdef DMEM_STATS_EN
  logic [31:0] wr_count_q, wr_count_d;

  always_comb begin
    wr_count_d = wr_count_q;
    if (wb_drain && (wr_count_q != 32'hFFFF_FFFF)) begin
      wr_count_d = wr_count_q + 32'd1;
    end else begin
      wr_count_d = wr_count_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_count_q <= 32'd0;
    end else begin
      wr_count_q <= wr_count_d;
    end
  end

  assign bus.o_wr_count = wr_count_q;
`else
  assign bus.o_wr_count = 32'd0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: read expectations go through a
// scoreboard queue; register-style outputs are checked inline per scenario.
module tb_data_mem_responder;

  logic clk;
  logic rst;

  data_mem_responder_if #(.XLEN(32)) bus ();

  data_mem_responder dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

`ifdef DMEM_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] exp;
  } rd_exp_t;

  rd_exp_t sb_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_write(input logic [31:0] a, input logic [31:0] d);
    bus.i_addr   = a;
    bus.i_wvalid = 1'b1;
    bus.i_wdata  = d;
    @(negedge clk);
    bus.i_wvalid = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rd_exp_t e;
    n_tests++;
    if (bus.o_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", bus.o_err); end
    n_tests++;
    if (bus.o_err_addr !== 32'h0) begin n_fail++; $display("FAIL rst_err_addr: got %h want 0", bus.o_err_addr); end
    n_tests++;
    if (bus.o_wr_count !== 32'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", bus.o_wr_count); end

    drive_write(32'h0000_2010, 32'hA5A5_0001);
    @(negedge clk);
    drive_write(32'h0000_1000, 32'h0000_0000);
    n_tests++;
    if (bus.o_err !== 1'b1) begin n_fail++; $display("FAIL rst_pre_err: got %b want 1", bus.o_err); end

    drive_write(32'h0000_2010, 32'hBBBB_0002);
    sb_q.push_back('{"rst_pending_fwd", 32'h0000_2010, 32'hBBBB_0002});
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      bus.i_addr = e.addr;
      #1;
      n_tests++;
      if (bus.o_rdata !== e.exp) begin n_fail++; $display("FAIL %s: rdata=%h want %h", e.name, bus.o_rdata, e.exp); end
    end

    // Reset lands mid-cycle while the new word still sits in the buffer.
    #1 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if (bus.o_err !== 1'b0) begin n_fail++; $display("FAIL rst_mid_err: got %b want 0", bus.o_err); end
    n_tests++;
    if (bus.o_err_addr !== 32'h0) begin n_fail++; $display("FAIL rst_mid_err_addr: got %h want 0", bus.o_err_addr); end
    n_tests++;
    if (bus.o_wr_count !== 32'd0) begin n_fail++; $display("FAIL rst_mid_count: got %0d want 0", bus.o_wr_count); end

    sb_q.push_back('{"rst_old_word", 32'h0000_2010, 32'hA5A5_0001});
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      bus.i_addr = e.addr;
      #1;
      n_tests++;
      if (bus.o_rdata !== e.exp) begin n_fail++; $display("FAIL %s: rdata=%h want %h", e.name, bus.o_rdata, e.exp); end
    end
    @(negedge clk);
  endtask

  task automatic test_forwarding();
    rd_exp_t e;
    drive_write(32'h0000_2000, 32'hDEAD_BEEF);
    sb_q.push_back('{"fwd_w0", 32'h0000_2000, 32'hDEAD_BEEF});
    sb_q.push_back('{"fwd_h2", 32'h0000_2002, 32'h0000_DEAD});
    sb_q.push_back('{"fwd_b3", 32'h0000_2003, 32'h0000_00DE});
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      bus.i_addr = e.addr;
      #1;
      n_tests++;
      if (bus.o_rdata !== e.exp) begin n_fail++; $display("FAIL %s: rdata=%h want %h", e.name, bus.o_rdata, e.exp); end
    end
    @(negedge clk);
    sb_q.push_back('{"ram_b1", 32'h0000_2001, 32'h00DE_ADBE});
    sb_q.push_back('{"ram_w0", 32'h0000_2000, 32'hDEAD_BEEF});
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      bus.i_addr = e.addr;
      #1;
      n_tests++;
      if (bus.o_rdata !== e.exp) begin n_fail++; $display("FAIL %s: rdata=%h want %h", e.name, bus.o_rdata, e.exp); end
    end
    n_tests++;
    if (bus.o_err !== 1'b0) begin n_fail++; $display("FAIL fwd_err: got %b want 0", bus.o_err); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    rd_exp_t e;
    logic [31:0] exp_cnt;
    pulse_reset();
    drive_write(32'h0000_2004, 32'h0000_0011);
    drive_write(32'h0000_2004, 32'h0000_0022);
    drive_write(32'h0000_2008, 32'h0000_0033);
    @(negedge clk);
    exp_cnt = STATS ? 32'd3 : 32'd0;
    n_tests++;
    if (bus.o_wr_count !== exp_cnt) begin n_fail++; $display("FAIL b2b_count: got %0d want %0d", bus.o_wr_count, exp_cnt); end
    n_tests++;
    if (bus.o_err !== 1'b0) begin n_fail++; $display("FAIL b2b_err: got %b want 0", bus.o_err); end
    sb_q.push_back('{"b2b_w4", 32'h0000_2004, 32'h0000_0022});
    sb_q.push_back('{"b2b_w8", 32'h0000_2008, 32'h0000_0033});
    sb_q.push_back('{"b2b_b5", 32'h0000_2005, 32'h0000_0000});
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      bus.i_addr = e.addr;
      #1;
      n_tests++;
      if (bus.o_rdata !== e.exp) begin n_fail++; $display("FAIL %s: rdata=%h want %h", e.name, bus.o_rdata, e.exp); end
    end
    @(negedge clk);
  endtask

  task automatic test_faults();
    rd_exp_t e;
    pulse_reset();
    drive_write(32'h0000_1FFC, 32'h1234_5678);
    n_tests++;
    if (bus.o_err !== 1'b1) begin n_fail++; $display("FAIL flt_err: got %b want 1", bus.o_err); end
    n_tests++;
    if (bus.o_err_addr !== 32'h0000_1FFC) begin n_fail++; $display("FAIL flt_addr: got %h want 00001ffc", bus.o_err_addr); end
    drive_write(32'h0000_2001, 32'h5555_5555);
    @(negedge clk);
    n_tests++;
    if (bus.o_err_addr !== 32'h0000_1FFC) begin n_fail++; $display("FAIL flt_addr_held: got %h want 00001ffc", bus.o_err_addr); end
    n_tests++;
    if (bus.o_wr_count !== 32'd0) begin n_fail++; $display("FAIL flt_count: got %0d want 0", bus.o_wr_count); end
    sb_q.push_back('{"flt_ram_kept", 32'h0000_2000, 32'hDEAD_BEEF});
    sb_q.push_back('{"flt_oor_read", 32'h0000_1FFC, 32'h0000_0000});
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      bus.i_addr = e.addr;
      #1;
      n_tests++;
      if (bus.o_rdata !== e.exp) begin n_fail++; $display("FAIL %s: rdata=%h want %h", e.name, bus.o_rdata, e.exp); end
    end
    @(negedge clk);
  endtask

  task automatic test_boundary();
    rd_exp_t e;
    pulse_reset();
    drive_write(32'h0000_2FFC, 32'hCAFE_F00D);
    @(negedge clk);
    n_tests++;
    if (bus.o_err !== 1'b0) begin n_fail++; $display("FAIL bnd_last_err: got %b want 0", bus.o_err); end
    sb_q.push_back('{"bnd_last_w", 32'h0000_2FFC, 32'hCAFE_F00D});
    sb_q.push_back('{"bnd_last_h", 32'h0000_2FFE, 32'h0000_CAFE});
    sb_q.push_back('{"bnd_first_w", 32'h0000_2000, 32'hDEAD_BEEF});
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      bus.i_addr = e.addr;
      #1;
      n_tests++;
      if (bus.o_rdata !== e.exp) begin n_fail++; $display("FAIL %s: rdata=%h want %h", e.name, bus.o_rdata, e.exp); end
    end
    @(negedge clk);
    drive_write(32'h0000_3000, 32'h0000_0001);
    n_tests++;
    if (bus.o_err !== 1'b1) begin n_fail++; $display("FAIL bnd_end_err: got %b want 1", bus.o_err); end
    n_tests++;
    if (bus.o_err_addr !== 32'h0000_3000) begin n_fail++; $display("FAIL bnd_end_addr: got %h want 00003000", bus.o_err_addr); end
    sb_q.push_back('{"bnd_end_read", 32'h0000_3000, 32'h0000_0000});
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      bus.i_addr = e.addr;
      #1;
      n_tests++;
      if (bus.o_rdata !== e.exp) begin n_fail++; $display("FAIL %s: rdata=%h want %h", e.name, bus.o_rdata, e.exp); end
    end
    @(negedge clk);
  endtask

  task automatic test_stats();
    logic [31:0] exp_cnt;
    pulse_reset();
    drive_write(32'h0000_2030, 32'h0000_0001);
    drive_write(32'h0000_1000, 32'h0000_0002);
    drive_write(32'h0000_2034, 32'h0000_0003);
    drive_write(32'h0000_2035, 32'h0000_0004);
    @(negedge clk);
    exp_cnt = STATS ? 32'd2 : 32'd0;
    n_tests++;
    if (bus.o_wr_count !== exp_cnt) begin n_fail++; $display("FAIL stats_count: got %0d want %0d", bus.o_wr_count, exp_cnt); end
    n_tests++;
    if (bus.o_err_addr !== 32'h0000_1000) begin n_fail++; $display("FAIL stats_err_addr: got %h want 00001000", bus.o_err_addr); end
  endtask

  initial begin
    rst          = 1'b1;
    bus.i_addr   = 32'h0;
    bus.i_wvalid = 1'b0;
    bus.i_wdata  = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_forwarding();
    test_back_to_back();
    test_faults();
    test_boundary();
    test_stats();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
